// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial two's-complement datapath:
// per-word mode encodings and the emit-stage state type.
package serial_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_NEG  = 2'd1;
    localparam logic [1:0] MODE_ABS  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } emit_state_t;

endpackage

// File: rtl/serial_comp_cell.sv
// One-bit Mealy two's-complement cell: passes bits unchanged up to and
// including the first 1, then inverts the rest of the word when negating.
module serial_comp_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_neg,
    input  logic i_b,
    output logic o_y,
    output logic o_seen
);

    logic r_seen;
    logic w_seenEff;

    // A clear on the same cycle as the first bit makes that bit see a fresh word.
    assign w_seenEff = r_seen & ~i_clr;
    assign o_y       = (i_neg & w_seenEff) ? ~i_b : i_b;
    assign o_seen    = r_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen <= 1'b0;
        end else if (i_en) begin
            r_seen <= w_seenEff | (i_neg & i_b);
        end else if (i_clr) begin
            r_seen <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_twos_neg.sv
// Bit-serial LSB-first PASS / NEG / ABS unit: captures a full word, then
// emits the result one registered bit per cycle with framing and overflow.
module serial_twos_neg
    import serial_pkg::*;
#(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    input  logic       i_in_bit,
    input  logic [1:0] i_mode,
    output logic       o_out_valid,
    output logic       o_out_bit,
    output logic       o_out_last,
    output logic       o_ovf
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] r_inCnt;
    logic [W-2:0]  r_cap;
    logic [1:0]    r_mode;
    logic [W-1:0]  r_emWord;
    logic          r_emNeg;
    emit_state_t   r_state;
    emit_state_t   w_nextState;
    logic [CW-1:0] r_outCnt;
    logic [CW-1:0] w_nextCnt;
    logic [CW-1:0] w_idx;

    logic [W-1:0]  w_word;
    logic          w_xfer;
    logic          w_neg;
    logic          w_cellB;
    logic          w_cellNeg;
    logic          w_cellClr;
    logic          w_cellEn;
    logic          w_cellY;
    logic          w_seen;
    logic          w_nextValid;
    logic          w_nextLast;
    logic          w_nextOvf;

    // The incoming bit completes the word on the transfer edge; sign arrives last.
    assign w_word = {i_in_bit, r_cap};
    assign w_xfer = i_in_valid && (r_inCnt == LAST);
    assign w_neg  = (r_mode == MODE_NEG) || ((r_mode == MODE_ABS) && i_in_bit);
    assign w_idx  = r_outCnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inCnt <= '0;
            r_cap   <= '0;
            r_mode  <= MODE_PASS;
        end else if (i_in_valid) begin
            r_cap   <= w_word[W-1:1];
            r_inCnt <= w_xfer ? '0 : r_inCnt + 1'b1;
            if (r_inCnt == '0) begin
                r_mode <= i_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_emWord <= '0;
            r_emNeg  <= 1'b0;
        end else if (w_xfer) begin
            r_emWord <= w_word;
            r_emNeg  <= w_neg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_outCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_outCnt <= w_nextCnt;
        end
    end

    // The cell works one bit ahead so every result bit can be registered.
    always_comb begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
        w_cellB     = 1'b0;
        w_cellNeg   = 1'b0;
        w_cellClr   = 1'b0;
        w_cellEn    = 1'b0;
        w_nextValid = 1'b0;
        w_nextLast  = 1'b0;
        w_nextOvf   = 1'b0;
        if (w_xfer) begin
            w_nextState = EMIT;
            w_cellB     = w_word[0];
            w_cellNeg   = w_neg;
            w_cellClr   = 1'b1;
            w_cellEn    = 1'b1;
            w_nextValid = 1'b1;
        end else if ((r_state == EMIT) && (r_outCnt != LAST)) begin
            w_nextState = EMIT;
            w_nextCnt   = w_idx;
            w_cellB     = r_emWord[w_idx];
            w_cellNeg   = r_emNeg;
            w_cellEn    = 1'b1;
            w_nextValid = 1'b1;
            w_nextLast  = (w_idx == LAST);
            w_nextOvf   = w_nextLast & r_emNeg & ~w_seen & r_emWord[w_idx];
        end
    end

    serial_comp_cell u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cellClr),
        .i_en   (w_cellEn),
        .i_neg  (w_cellNeg),
        .i_b    (w_cellB),
        .o_y    (w_cellY),
        .o_seen (w_seen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_out_valid <= 1'b0;
            o_out_bit   <= 1'b0;
            o_out_last  <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            o_out_valid <= w_nextValid;
            o_out_bit   <= w_nextValid & w_cellY;
            o_out_last  <= w_nextLast;
            o_ovf       <= w_nextOvf;
        end
    end

endmodule

// File: tb/tb_serial_twos_neg.sv
// Directed self-checking bench for serial_twos_neg (W=8) with hand-computed results.
module tb_serial_twos_neg;

    logic       clk;
    logic       rst_n;
    logic       i_in_valid;
    logic       i_in_bit;
    logic [1:0] i_mode;
    logic       o_out_valid;
    logic       o_out_bit;
    logic       o_out_last;
    logic       o_ovf;

    int nAssert = 0;
    int nFail   = 0;

    serial_twos_neg #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .i_in_bit    (i_in_bit),
        .i_mode      (i_mode),
        .o_out_valid (o_out_valid),
        .o_out_bit   (o_out_bit),
        .o_out_last  (o_out_last),
        .o_ovf       (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Drives nBits LSB-first starting #1 after an edge; optional gap after bit gapAt.
    task automatic applyStimulus(input logic [7:0] w, input logic [1:0] m, input int nBits,
                                 input int gapAt, input int gapLen, input logic [1:0] lateMode);
        for (int i = 0; i < nBits; i++) begin
            i_in_valid = 1'b1;
            i_in_bit   = w[i];
            i_mode     = (i > gapAt) ? lateMode : m;
            @(posedge clk); #1;
            if (i == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    i_in_valid = 1'b0;
                    i_in_bit   = ~w[i];
                    i_mode     = lateMode;
                    @(posedge clk); #1;
                end
            end
        end
        i_in_valid = 1'b0;
        i_in_bit   = 1'b0;
    endtask

    // Called #1 after the edge that sampled the last input bit.
    task automatic checkWord(input string tag, input logic [7:0] exp, input logic expOvf,
                             input logic idleAfter);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s valid[%0d]", tag, k), o_out_valid, 1'b1);
            checkOutput($sformatf("%s bit[%0d]", tag, k), o_out_bit, exp[k]);
            checkOutput($sformatf("%s last[%0d]", tag, k), o_out_last, (k == 7) ? 1'b1 : 1'b0);
            checkOutput($sformatf("%s ovf[%0d]", tag, k), o_ovf, (k == 7) ? expOvf : 1'b0);
            @(posedge clk); #1;
        end
        if (idleAfter) begin
            checkOutput({tag, " idle"}, o_out_valid, 1'b0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_in_valid = 1'b0;
        i_in_bit   = 1'b0;
        i_mode     = 2'd0;
        #3;
        checkOutput("reset valid", o_out_valid, 1'b0);
        checkOutput("reset bit", o_out_bit, 1'b0);
        checkOutput("reset last", o_out_last, 1'b0);
        checkOutput("reset ovf", o_ovf, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset idle", o_out_valid, 1'b0);

        applyStimulus(8'h68, 2'd1, 8, 99, 0, 2'd1);
        checkWord("NEG 68", 8'h98, 1'b0, 1'b1);

        applyStimulus(8'hF6, 2'd2, 8, 99, 0, 2'd2);
        checkWord("ABS F6", 8'h0A, 1'b0, 1'b1);

        applyStimulus(8'h05, 2'd2, 8, 99, 0, 2'd2);
        checkWord("ABS 05", 8'h05, 1'b0, 1'b1);

        applyStimulus(8'h80, 2'd1, 8, 99, 0, 2'd1);
        checkWord("NEG 80", 8'h80, 1'b1, 1'b1);

        applyStimulus(8'h00, 2'd1, 8, 99, 0, 2'd1);
        checkWord("NEG 00", 8'h00, 1'b0, 1'b1);

        applyStimulus(8'h96, 2'd3, 8, 99, 0, 2'd3);
        checkWord("RSVD 96", 8'h96, 1'b0, 1'b1);

        fork
            begin
                applyStimulus(8'hA5, 2'd0, 8, 99, 0, 2'd0);
                applyStimulus(8'h01, 2'd1, 8, 99, 0, 2'd1);
                applyStimulus(8'h80, 2'd2, 8, 99, 0, 2'd2);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                checkWord("B2B PASS A5", 8'hA5, 1'b0, 1'b0);
                checkWord("B2B NEG 01", 8'hFF, 1'b0, 1'b0);
                checkWord("B2B ABS 80", 8'h80, 1'b1, 1'b1);
            end
        join

        applyStimulus(8'h68, 2'd1, 8, 3, 3, 2'd0);
        checkWord("GAP NEG 68", 8'h98, 1'b0, 1'b1);

        applyStimulus(8'h68, 2'd1, 8, 99, 0, 2'd1);
        applyStimulus(8'hFF, 2'd2, 4, 99, 0, 2'd2);
        checkOutput("pre-reset emitting", o_out_valid, 1'b1);
        checkOutput("pre-reset bit4", o_out_bit, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", o_out_valid, 1'b0);
        checkOutput("async reset bit", o_out_bit, 1'b0);
        checkOutput("async reset last", o_out_last, 1'b0);
        checkOutput("async reset ovf", o_ovf, 1'b0);
        @(posedge clk); #1;
        checkOutput("held reset valid", o_out_valid, 1'b0);
        rst_n = 1'b1;
        applyStimulus(8'h3C, 2'd0, 8, 99, 0, 2'd0);
        checkWord("post-reset PASS 3C", 8'h3C, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/serial_twos_neg.md
# serial_twos_neg

Bit-serial, LSB-first two's-complement arithmetic unit for W-bit words, with per-word mode select: pass, negate or absolute value. It is the parametrised successor to the single-stream serial complementer.
- Adds word framing, a valid qualifier, a full-word buffer (so ABS can see the sign bit, which arrives last) and an overflow flag.
- Sits between a serial source and a serial sink in the lab datapaths.

## Interface
- W, 8, word width in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_bit is a valid serial data bit this cycle
- in_bit  in  1  serial data, LSB first
- mode  in  2  0 PASS, 1 NEG, 2 ABS, 3 reserved (behaves as PASS); sampled with bit 0 of each word
- out_valid  out  1  out_bit is valid
- out_bit  out  1  serial result, LSB first
- out_last  out  1  high with the MSB of each result word
- ovf  out  1  high with out_last when a negation wrapped (input was 100…0)

## Operation
- Capture side:
  - in_cnt (0..W-1) advances only on in_valid; gaps hold the state.
  - Bits shift into the capture register cap.
  - mode is latched when in_cnt==0 && in_valid.
- Word transfer: the edge that samples bit W-1 moves the full word, the latched mode and sign = bit W-1 into the emit stage, and resets in_cnt to 0.
- Emit FSM:
  - IDLE: outputs low.
  - EMIT: one bit per cycle for exactly W cycles, no backpressure. The output counter runs 0..W-1.
  - Transition EMIT→IDLE after bit W-1, unless a new transfer lands on that edge; then it stays in EMIT and restarts at bit 0.
- Negation decision: neg = (mode==NEG) | (mode==ABS & sign).
- Per-bit complement cell:
  - If neg: out_bit = seen ? ~b : b, then seen |= b.
  - Otherwise out_bit = b.
  - seen is cleared at the start of each emitted word.
- Overflow: ovf = neg & (bits 0..W-2 all zero) & (bit W-1 == 1). The result is then 100…0, i.e. it wraps.
- Reset values: all outputs 0, in_cnt 0, seen 0, FSM IDLE, cap and emit registers 0.
- Reset asserted mid-word or mid-emission:
  - The partial input word and any in-flight output are discarded.
  - out_valid drops immediately, since the reset is asynchronous.
  - Capture restarts at bit 0 after release.

## Timing
- All outputs are registered.
- Latency: the first result bit appears on the cycle after the edge that samples input bit W-1. Result bit k appears k+1 cycles after that edge.
- out_valid stays high for exactly W consecutive cycles per word. out_last and ovf are asserted only on the W-th of those cycles.
- Back-to-back: with in_valid continuously high, out_valid is continuously high. There are no bubbles between words.
- Buffering never overruns, because the input needs ≥W cycles per word and emission takes exactly W cycles.
- mode changes mid-word have no effect until the next word's bit 0.

## Structure
- Shared package serial_pkg holds:
  - mode constants MODE_PASS=2'd0, MODE_NEG=2'd1, MODE_ABS=2'd2, MODE_RSVD=2'd3;
  - the emit state enum {IDLE, EMIT}.
- Sub-module serial_comp_cell: a 1-bit Mealy complementer.
  - Ports: clk, reset, clr, en, neg, b; outputs y and seen.
  - Instantiated once in the emit stage.
- Top level holds the capture counter and register, the transfer logic, the emit FSM and the overflow detection.

## Test plan
(W=8; words are written MSB→LSB in hex and driven LSB first.)
- NEG, in 0x68 (bits 0,0,0,1,0,1,1,0) → out 0x98 (bits 0,0,0,1,1,0,0,1). Required timing: out_valid for 8 cycles starting 1 cycle after the last input bit; out_last on the 8th; ovf 0.
- ABS, in 0xF6 (−10) → 0x0A. ABS, in 0x05 → 0x05 unchanged. ovf 0 for both.
- NEG, in 0x80 → 0x80 with ovf=1 on out_last. NEG, in 0x00 → 0x00 with ovf 0.
- Back-to-back with continuous in_valid: PASS 0xA5, then NEG 0x01, then ABS 0x80. Required: out_valid high for 24 contiguous cycles, output 0xA5, 0xFF, 0x80 (ovf=1 on the third word only).
- NEG 0x68 with in_valid low for 3 cycles after bit 3, and mode toggled during the gap → still 0x98, identical output timing relative to the last input bit.
- Reset asserted after 4 input bits while the previous word is emitting → all outputs 0 immediately. After release, PASS 0x3C → 0x3C, with no residue from the aborted word.
